llc_bus_unit: RTL and testbench
===============================

// Module: llc_bus_unit
// PURPOSE
//  Downstream bus-interface stage of the LLC: accepts bus operations (READ, WRITE, INVALIDATE, RWIM)
//  issued by the LLC, queues them, and runs each on the shared system bus. Per operation it does
//  address handshake, snoop-result sampling, HITM back-off/retry and data-beat counting, then returns
//  the snoop result to the LLC on a valid/ready response channel.
// PARAMETERS
//  ADDR_BITS       32  address width; must match the LLC address width
//  FIFO_DEPTH      4   request queue entries; power of 2, >=2
//  DATA_BEATS      8   bus data beats per line transfer; >=1
//  BACKOFF_CYCLES  4   idle cycles after a HITM before the operation is reissued; >=1
//  MAX_RETRY       3   maximum HITM reissues per operation; 0 disables retry
// PORTS
//  clk          in   1          clock; all state updates on rising edge
//  rst          in   1          asynchronous, active-high reset
//  req_valid    in   1          LLC bus-op request valid
//  req_ready    out  1          queue can accept a request (= !full)
//  req_op       in   2          0=READ 1=WRITE 2=INVALIDATE 3=RWIM
//  req_addr     in   ADDR_BITS  line address; byte-offset bits are passed through unchanged
//  rsp_valid    out  1          operation complete; payload is valid
//  rsp_ready    in   1          LLC accepts the response
//  rsp_op       out  2          op of the completed request
//  rsp_addr     out  ADDR_BITS  address of the completed request
//  rsp_snoop    out  2          final snoop result: 0=HIT 1=HITM 2=NOHIT
//  bus_req      out  1          bus address phase request
//  bus_op       out  2          op driven on the bus
//  bus_addr     out  ADDR_BITS  address driven on the bus
//  bus_gnt      in   1          bus grant; completes the address phase
//  bus_snoop    in   2          snoop response; sampled in the cycle after grant
//  bus_beat     in   1          one data beat transferred this cycle
//  busy         out  1          state != IDLE or queue non-empty
//  ops_done     out  32         count of completed responses; wraps modulo 2^32
// BEHAVIOUR
//  Reset: every output 0 (req_ready=1 once rst deasserts), queue empty, state IDLE, counters 0.
//   Reset during any state abandons the in-flight op and all queued ops with no response issued.
//  Queue: push on req_valid&&req_ready. req_ready=0 when full; no bypass path, so a push into a full
//   queue is impossible even when a pop happens in the same cycle. Pop occurs only on IDLE->ADDR.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, ADDR, SNOOP, BACKOFF, DATA, RESP.
//   IDLE: if queue non-empty, pop the head into the op register, then ADDR.
//   ADDR: bus_req=1; bus_op/bus_addr held stable. On bus_gnt=1 -> SNOOP, with bus_req dropping in the same edge.
//   SNOOP: sample bus_snoop once (2'b11 is treated as NOHIT=2).
//    - READ/RWIM with HITM and retry_cnt<MAX_RETRY: retry_cnt++ and go to BACKOFF.
//    - INVALIDATE: go to RESP.
//    - otherwise: go to DATA. This includes HITM once retries are exhausted; rsp_snoop then reports HITM.
//   BACKOFF: count BACKOFF_CYCLES cycles, then go to ADDR and reissue the identical op/address.
//   DATA: count bus_beat pulses from 0 to DATA_BEATS-1. When the final beat is seen, go to RESP.
//    bus_beat outside the DATA state is ignored.
//   RESP: rsp_valid=1 with op/addr/snoop held stable until rsp_ready. On the handshake edge:
//    ops_done++, retry_cnt=0, state -> IDLE.
//  Latency: a push into an empty queue at edge k, with the FSM in IDLE, makes bus_req high after edge k+2.
//   With no stalls, INVALIDATE goes gnt -> rsp_valid in 2 edges, and READ goes gnt -> rsp_valid in DATA_BEATS+2 edges.
//  One op is outstanding on the bus at a time. Responses are issued in request order.
// TESTING
//  1 READ 0x1000, gnt next cycle, snoop NOHIT, 8 beats -> rsp_valid with op=0 addr=0x1000 snoop=2; ops_done=1.
//  2 READ 0x2001 with HITM twice, then HIT -> bus_req reasserted twice, each after exactly 4 idle cycles;
//    final rsp_snoop=0.
//  3 RWIM with HITM on every sample -> 4 address phases total (1 + MAX_RETRY=3), then DATA; rsp_snoop=1.
//  4 Push 5 ops while bus_gnt is held low -> req_ready drops after 4 accepted while 1 op waits in ADDR;
//    responses return in order.
//  5 INVALIDATE 0x3000 -> no DATA state (stray bus_beat pulses ignored); rsp 2 edges after gnt;
//    rsp_ready held low for 3 cycles -> payload held stable throughout.
//  6 Assert rst during DATA with 2 ops queued -> outputs 0 immediately, busy=0, no rsp_valid after release.

Source files
------------

// File: rtl/llc_bus_unit.sv
// llc_bus_unit: queues LLC bus operations and runs each one on the system bus,
// handling address handshake, snoop sampling, HITM back-off/retry and data beats.
module llc_bus_unit #(
    parameter int ADDR_BITS      = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int DATA_BEATS     = 8,
    parameter int BACKOFF_CYCLES = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_op,
    output logic [ADDR_BITS-1:0] rsp_addr,
    output logic [1:0]           rsp_snoop,
    output logic                 bus_req,
    output logic [1:0]           bus_op,
    output logic [ADDR_BITS-1:0] bus_addr,
    input  logic                 bus_gnt,
    input  logic [1:0]           bus_snoop,
    input  logic                 bus_beat,
    output logic                 busy,
    output logic [31:0]          ops_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DATA_BEATS + 1);
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [AW:0]    CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [DW-1:0]  BEAT_LAST = DW'(DATA_BEATS - 1);
    localparam logic [BW-1:0]  BO_LAST   = BW'(BACKOFF_CYCLES - 1);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [1:0]     OP_READ = 2'd0, OP_INV = 2'd2, OP_RWIM = 2'd3, SNP_HITM = 2'd1;

    typedef enum logic [2:0] {IDLE, ADDR, SNOOP, BACKOFF, DATA, RESP} state_t;
    state_t state, state_n;

    logic [ADDR_BITS+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 ne;
    logic [1:0]           op, snoop;
    logic [ADDR_BITS-1:0] addr;
    logic [RW-1:0]        retry;
    logic [BW-1:0]        boff;
    logic [DW-1:0]        beat;
    logic                 push, pop, retry_ok;

    assign req_ready = ~rst & (count != CNT_FULL);
    assign push      = req_valid & req_ready;
    // ne lags the occupancy by one edge, giving the two-edge push-to-bus_req latency
    assign pop       = (state == IDLE) & ne;
    assign retry_ok  = (op == OP_READ || op == OP_RWIM) && bus_snoop == SNP_HITM && retry < RETRY_MAX;

    assign bus_req   = state == ADDR;
    assign bus_op    = op;
    assign bus_addr  = addr;
    assign rsp_valid = state == RESP;
    assign rsp_op    = op;
    assign rsp_addr  = addr;
    assign rsp_snoop = snoop;
    assign busy      = (state != IDLE) | (count != '0);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = ne ? ADDR : IDLE;
            ADDR:    state_n = bus_gnt ? SNOOP : ADDR;
            SNOOP:   state_n = op == OP_INV ? RESP : retry_ok ? BACKOFF : DATA;
            BACKOFF: state_n = boff == BO_LAST ? ADDR : BACKOFF;
            DATA:    state_n = (bus_beat && beat == BEAT_LAST) ? RESP : DATA;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {req_op, req_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ne       <= 1'b0;
            op       <= '0;
            addr     <= '0;
            snoop    <= '0;
            retry    <= '0;
            boff     <= '0;
            beat     <= '0;
            ops_done <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                {op, addr} <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            ne    <= count != '0;
            if (state == SNOOP) begin
                snoop <= bus_snoop == 2'b11 ? 2'd2 : bus_snoop;
                if (retry_ok) retry <= retry + 1'b1;
            end
            boff <= state == BACKOFF ? boff + 1'b1 : '0;
            beat <= state == DATA ? beat + DW'(bus_beat) : '0;
            if (state == RESP && rsp_ready) begin
                ops_done <= ops_done + 32'd1;
                retry    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_llc_bus_unit.sv
// tb_llc_bus_unit: directed and randomized checks of llc_bus_unit against a
// request-level model of retries, snoop outcome, latency and response order.
module tb_llc_bus_unit;
    localparam int AB = 32, FD = 4, DB = 8, BO = 4, MR = 3;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, INV = 2'd2, RWIM = 2'd3;

    logic          clk = 1'b0, rst;
    logic          req_valid, req_ready, rsp_valid, rsp_ready, bus_req, bus_gnt, bus_beat, busy;
    logic [1:0]    req_op, rsp_op, rsp_snoop, bus_op, bus_snoop;
    logic [AB-1:0] req_addr, rsp_addr, bus_addr;
    logic [31:0]   ops_done;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        int          h;
        logic [1:0]  v;
    } req_t;

    req_t pend[$];
    int   tests = 0, fails = 0, done = 0;

    llc_bus_unit #(.ADDR_BITS(AB), .FIFO_DEPTH(FD), .DATA_BEATS(DB), .BACKOFF_CYCLES(BO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_addr(rsp_addr), .rsp_snoop(rsp_snoop), .bus_req(bus_req), .bus_op(bus_op),
        .bus_addr(bus_addr), .bus_gnt(bus_gnt), .bus_snoop(bus_snoop), .bus_beat(bus_beat),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] addr, input int h, input logic [1:0] v);
        int w = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        while (!req_ready && w < 200) begin
            tick();
            w++;
        end
        chk("push_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        pend.push_back('{op, addr, h, v});
    endtask

    // Bus side and response side of one request, derived from the retry rules:
    // READ/RWIM reissue on HITM up to MR times; other ops never reissue.
    task automatic serve(input int gdly, input int hold);
        req_t r = pend.pop_front();
        int phases = (r.op == RD || r.op == RWIM) ? ((r.h > MR) ? MR + 1 : r.h + 1) : 1;
        logic [1:0] s = 2'd0;
        logic [1:0] exp_snp;
        for (int i = 0; i < phases; i++) begin
            int w = 0;
            while (!bus_req && w < 300) begin
                bus_beat = 1'($urandom);
                tick();
                w++;
            end
            bus_beat = 1'b0;
            chk("bus_req_seen", bus_req, 1);
            if (i > 0) chk("backoff_gap", w, BO);
            chk("bus_op", bus_op, r.op);
            chk("bus_addr", bus_addr, r.addr);
            for (int g = 0; g < gdly; g++) begin
                tick();
                chk("bus_req_hold", bus_req, 1);
            end
            bus_gnt = 1'b1;
            tick();
            bus_gnt = 1'b0;
            chk("bus_req_drop", bus_req, 0);
            s = (i < r.h) ? 2'd1 : r.v;
            bus_snoop = s;
            bus_beat  = 1'($urandom);
            tick();
            bus_snoop = 2'd0;
            bus_beat  = 1'b0;
        end
        if (r.op != INV) begin
            for (int b = 0; b < DB; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                chk("rsp_early", rsp_valid, 0);
                bus_beat = 1'b1;
                tick();
                bus_beat = 1'b0;
            end
        end
        chk("rsp_latency", rsp_valid, 1);
        exp_snp = (s == 2'd3) ? 2'd2 : s;
        for (int d = 0; d <= hold; d++) begin
            if (d > 0) tick();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_op", rsp_op, r.op);
            chk("rsp_addr", rsp_addr, r.addr);
            chk("rsp_snoop", rsp_snoop, exp_snp);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        done++;
        chk("ops_done", ops_done, done);
    endtask

    initial begin
        logic [1:0] rop;
        rst = 1'b1;
        {req_valid, rsp_ready, bus_gnt, bus_beat} = '0;
        req_op = '0;
        req_addr = '0;
        bus_snoop = '0;
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ops_done", ops_done, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1);

        // 1: plain READ with push-to-bus_req latency of two edges
        push(RD, 32'h1000, 0, 2'd2);
        chk("lat_k", bus_req, 0);
        chk("busy_k", busy, 1);
        tick();
        chk("lat_k1", bus_req, 0);
        tick();
        chk("lat_k2", bus_req, 1);
        serve(1, 0);

        // 2: two HITMs then HIT
        push(RD, 32'h2001, 2, 2'd0);
        serve(0, 0);
        // 3: RWIM with HITM on every sample, retries exhausted
        push(RWIM, 32'h4440, 9, 2'd1);
        serve(2, 1);

        // 4: five pushes against a stalled bus fill the queue behind the op in ADDR
        for (int i = 0; i < 5; i++) push(2'(i), 32'h5000 + 32'(i * 64), 0, 2'd2);
        chk("full_ready", req_ready, 0);
        chk("full_bus_req", bus_req, 1);
        for (int i = 0; i < 5; i++) serve(1, 0);

        // 5: INVALIDATE with stray beats and a stalled response
        push(INV, 32'h3000, 0, 2'd3);
        serve(0, 3);

        // randomized batches
        for (int b = 0; b < 8; b++) begin
            int n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                int vv = $urandom_range(0, 2);
                rop = 2'($urandom);
                push(rop, $urandom, $urandom_range(0, 4), vv == 0 ? 2'd0 : vv == 1 ? 2'd2 : 2'd3);
            end
            for (int i = 0; i < n; i++) serve($urandom_range(0, 2), $urandom_range(0, 2));
        end
        chk("idle_busy", busy, 0);

        // 6: reset mid-DATA with two ops still queued
        push(RD, 32'h6000, 0, 2'd2);
        push(WR, 32'h6040, 0, 2'd2);
        push(RWIM, 32'h6080, 0, 2'd2);
        while (!bus_req) tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_snoop = 2'd2;
        tick();
        bus_snoop = 2'd0;
        repeat (3) begin
            bus_beat = 1'b1;
            tick();
        end
        bus_beat = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_bus_req", bus_req, 0);
        chk("arst_bus_addr", bus_addr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_ops_done", ops_done, 0);
        tick();
        rst = 1'b0;
        pend.delete();
        done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_bus_req", bus_req, 0);
        end
        chk("post_rst_ready2", req_ready, 1);
        push(WR, 32'h7000, 1, 2'd0);
        serve(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
